// File: rtl/step_sequencer.sv
// step_sequencer: plays a 16-step note/gate pattern into one voice, one step per step_period ticks.
// Latency: outputs are registered; a sample_clock rise takes effect two clk edges later.
// Backpressure: none; pattern writes are accepted every cycle and playback is paced only by ticks.
module step_sequencer #(
   parameter int STEPS     = 16,
   parameter int NOTE_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sample_clock,
   input  logic                 run,
   input  logic [15:0]          step_period,
   input  logic [15:0]          gate_length,
   input  logic [3:0]           last_step,
   input  logic                 wr_en,
   input  logic [3:0]           wr_addr,
   input  logic [NOTE_BITS-1:0] wr_note,
   input  logic                 wr_active,
   output logic [NOTE_BITS-1:0] note,
   output logic                 gate,
   output logic [3:0]           step,
   output logic                 step_strobe
);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t               state_q, state_d;
   logic                 sc_prev_q, sc_prev_d;
   logic                 tick_q, tick_d;
   logic [15:0]          tick_count_q, tick_count_d;
   logic [NOTE_BITS-1:0] note_q, note_d;
   logic                 gate_q, gate_d;
   logic [3:0]           step_q, step_d;
   logic                 strobe_q, strobe_d;
   logic [NOTE_BITS-1:0] mem_note_q [STEPS];
   logic [NOTE_BITS-1:0] mem_note_d [STEPS];
   logic                 mem_act_q  [STEPS];
   logic                 mem_act_d  [STEPS];

   logic                 load;
   logic [3:0]           load_idx;
   logic [15:0]          period_m1;

   // Rising-edge detect of sample_clock; the tick is registered once more before use.
   always_comb begin
      sc_prev_d = sample_clock;
      tick_d    = sample_clock & ~sc_prev_q;
   end

   // Pattern memory write port; a load on the same edge still sees the old entry.
   always_comb begin
      mem_note_d = mem_note_q;
      mem_act_d  = mem_act_q;
      if (wr_en) begin
         mem_note_d[wr_addr] = wr_note;
         mem_act_d[wr_addr]  = wr_active;
      end
   end

   // Play FSM: start on a tick with run, advance on ticks, drop to idle as soon as run falls.
   always_comb begin
      state_d      = state_q;
      tick_count_d = tick_count_q;
      note_d       = note_q;
      gate_d       = gate_q;
      step_d       = step_q;
      strobe_d     = 1'b0;
      load         = 1'b0;
      load_idx     = 4'd0;
      // A zero period behaves as one tick per step.
      period_m1    = (step_period == 16'd0) ? 16'd0 : step_period - 16'd1;

      case (state_q)
         IDLE: begin
            gate_d       = 1'b0;
            step_d       = 4'd0;
            tick_count_d = 16'd0;
            if (tick_q && run) begin
               load     = 1'b1;
               load_idx = 4'd0;
               state_d  = PLAY;
            end
         end
         PLAY: begin
            if (!run) begin
               state_d      = IDLE;
               gate_d       = 1'b0;
               step_d       = 4'd0;
               tick_count_d = 16'd0;
            end else if (tick_q) begin
               // >= comparisons keep a shrunken period or length from running past the end.
               if (tick_count_q >= period_m1) begin
                  load     = 1'b1;
                  load_idx = (step_q >= last_step) ? 4'd0 : step_q + 4'd1;
               end else begin
                  tick_count_d = tick_count_q + 16'd1;
                  if (tick_count_q + 16'd1 >= gate_length) begin
                     gate_d = 1'b0;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         step_d       = load_idx;
         note_d       = mem_note_q[load_idx];
         gate_d       = mem_act_q[load_idx] && (gate_length != 16'd0);
         tick_count_d = 16'd0;
         strobe_d     = 1'b1;
      end
   end

   // State, output and memory registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sc_prev_q    <= 1'b1;
         tick_q       <= 1'b0;
         tick_count_q <= 16'd0;
         note_q       <= '0;
         gate_q       <= 1'b0;
         step_q       <= 4'd0;
         strobe_q     <= 1'b0;
         for (int i = 0; i < STEPS; i++) begin
            mem_note_q[i] <= '0;
            mem_act_q[i]  <= 1'b0;
         end
      end else begin
         state_q      <= state_d;
         sc_prev_q    <= sc_prev_d;
         tick_q       <= tick_d;
         tick_count_q <= tick_count_d;
         note_q       <= note_d;
         gate_q       <= gate_d;
         step_q       <= step_d;
         strobe_q     <= strobe_d;
         mem_note_q   <= mem_note_d;
         mem_act_q    <= mem_act_d;
      end
   end

   assign note        = note_q;
   assign gate        = gate_q;
   assign step        = step_q;
   assign step_strobe = strobe_q;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: randomized and directed bench for step_sequencer against a tick-level reference model.
// Latency: the model applies each detected sample_clock rise one clk edge after detection.
// Backpressure: none; the bench drives one edge at a time and samples 1 time unit after it.
module tb_step_sequencer;

   logic        clk = 1'b0;
   logic        rst, sample_clock, run, wr_en, wr_active;
   logic [15:0] step_period, gate_length;
   logic [3:0]  last_step, wr_addr;
   logic [7:0]  wr_note;
   logic [7:0]  note;
   logic        gate, step_strobe;
   logic [3:0]  step;

   int checks   = 0;
   int failures = 0;

   // Reference model: pattern contents plus position inside the current step, in ticks.
   logic [7:0] m_note_mem [16];
   logic       m_act_mem  [16];
   logic       m_play, m_gate, m_strobe;
   int         m_pos;
   logic [7:0] m_note;
   logic [3:0] m_step;

   // sample_clock waveform generator and tick bookkeeping.
   logic sc_prev, tick_pend, last_tk;
   int   sc_ph, sc_hi, sc_lo;
   bit   sc_rand;

   step_sequencer #(.STEPS(16), .NOTE_BITS(8)) dut (
      .clk(clk), .rst(rst), .sample_clock(sample_clock), .run(run),
      .step_period(step_period), .gate_length(gate_length), .last_step(last_step),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_active(wr_active),
      .note(note), .gate(gate), .step(step), .step_strobe(step_strobe)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_note_mem[i] = 8'd0;
         m_act_mem[i]  = 1'b0;
      end
      m_play = 0; m_gate = 0; m_strobe = 0; m_pos = 0; m_note = 8'd0; m_step = 4'd0;
      sc_prev = 1'b1; tick_pend = 1'b0; last_tk = 1'b0;
   endfunction

   function automatic void model_load(input logic [3:0] s);
      m_step   = s;
      m_note   = m_note_mem[s];
      m_pos    = 0;
      m_strobe = 1'b1;
      m_gate   = m_act_mem[s] && (gate_length != 16'd0);
   endfunction

   // One clk edge of the reference behaviour; tk means a tick is consumed at this edge.
   function automatic void model_edge(input logic tk);
      int per;
      per      = (step_period == 16'd0) ? 1 : int'(step_period);
      m_strobe = 1'b0;
      if (!m_play) begin
         m_gate = 0; m_step = 4'd0; m_pos = 0;
         if (tk && run) begin
            m_play = 1'b1;
            model_load(4'd0);
         end
      end else if (!run) begin
         m_play = 0; m_gate = 0; m_step = 4'd0; m_pos = 0;
      end else if (tk) begin
         if (m_pos + 1 >= per) begin
            model_load((m_step >= last_step) ? 4'd0 : m_step + 4'd1);
         end else begin
            m_pos  = m_pos + 1;
            m_gate = m_gate && (m_pos < int'(gate_length));
         end
      end
   endfunction

   // Advance one clk edge, update the model, then move the sample_clock waveform.
   task automatic edge1();
      logic tk;
      tk        = tick_pend;
      tick_pend = sample_clock & ~sc_prev;
      sc_prev   = sample_clock;
      @(posedge clk);
      #1;
      last_tk = tk;
      model_edge(tk);
      if (wr_en) begin
         m_note_mem[wr_addr] = wr_note;
         m_act_mem[wr_addr]  = wr_active;
      end
      sc_ph++;
      if (sc_ph >= (sample_clock ? sc_hi : sc_lo)) begin
         sample_clock = ~sample_clock;
         sc_ph        = 0;
         if (sc_rand) begin
            sc_hi = $urandom_range(3, 1);
            sc_lo = $urandom_range(3, 1);
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; wr_en = 1'b0;
      sc_rand = 0; sc_hi = 2; sc_lo = 2;
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
   endtask

   task automatic write_step(input logic [3:0] a, input logic [7:0] n, input logic act);
      wr_en = 1'b1; wr_addr = a; wr_note = n; wr_active = act;
      edge1();
      wr_en = 1'b0;
   endtask

   // Steps 0..3 = 60/64/67/72, active bits from mask.
   task automatic load_pattern(input logic [3:0] mask);
      write_step(4'd0, 8'd60, mask[0]);
      write_step(4'd1, 8'd64, mask[1]);
      write_step(4'd2, 8'd67, mask[2]);
      write_step(4'd3, 8'd72, mask[3]);
   endtask

   task automatic test_reset();
      do_reset();
      for (int e = 0; e < 6; e++) begin
         edge1();
         checks++;
         if ({note, gate, step, step_strobe} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state e=%0d got {note,gate,step,strobe}=%h want 0", e, {note, gate, step, step_strobe});
         end
      end
   endtask

   task automatic test_basic_run();
      int exp_notes[5] = '{60, 64, 67, 72, 60};
      int seen[$];
      int stb_edge[$];
      int gate_hi;
      gate_hi = 0;
      do_reset();
      load_pattern(4'hF);
      last_step = 4'd3; step_period = 16'd4; gate_length = 16'd2; run = 1'b1;
      for (int e = 0; e < 100; e++) begin
         edge1();
         checks++;
         if ({note, gate, step, step_strobe} !== {m_note, m_gate, m_step, m_strobe}) begin
            failures++;
            $display("FAIL basic_run e=%0d got %h want %h", e, {note, gate, step, step_strobe}, {m_note, m_gate, m_step, m_strobe});
         end
         if (step_strobe) begin
            seen.push_back(int'(note));
            stb_edge.push_back(e);
         end
         if (stb_edge.size() == 2 && gate) gate_hi++;
      end
      checks++;
      if (seen.size() < 5) begin
         failures++;
         $display("FAIL basic_strobes got %0d strobes want >=5", seen.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (seen[k] != exp_notes[k]) begin
               failures++;
               $display("FAIL basic_note_seq k=%0d got %0d want %0d", k, seen[k], exp_notes[k]);
            end
         end
         checks++;
         if (stb_edge[2] - stb_edge[1] != 16) begin
            failures++;
            $display("FAIL basic_step_len got %0d edges want 16", stb_edge[2] - stb_edge[1]);
         end
      end
      checks++;
      if (gate_hi != 8) begin
         failures++;
         $display("FAIL basic_gate_len got %0d edges want 8", gate_hi);
      end
   endtask

   task automatic test_legato();
      int bad;
      bit started, seen64;
      bad = 0; started = 0; seen64 = 0;
      do_reset();
      load_pattern(4'b1101);
      last_step = 4'd3; step_period = 16'd4; gate_length = 16'd8; run = 1'b1;
      for (int e = 0; e < 120; e++) begin
         edge1();
         checks++;
         if ({note, gate, step, step_strobe} !== {m_note, m_gate, m_step, m_strobe}) begin
            failures++;
            $display("FAIL legato e=%0d got %h want %h", e, {note, gate, step, step_strobe}, {m_note, m_gate, m_step, m_strobe});
         end
         if (step_strobe) started = 1;
         if (started) begin
            if (step == 4'd1) begin
               if (gate !== 1'b0) bad++;
               if (note == 8'd64) seen64 = 1;
            end else if (gate !== 1'b1) bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL legato_gate got %0d wrong gate edges want 0", bad);
      end
      checks++;
      if (!seen64) begin
         failures++;
         $display("FAIL muted_note got no note 64 in step 1 want 64");
      end
   endtask

   task automatic test_degenerate();
      int nstb, ntk, ngate;
      nstb = 0; ntk = 0; ngate = 0;
      do_reset();
      load_pattern(4'hF);
      last_step = 4'd3; step_period = 16'd0; gate_length = 16'd2; run = 1'b1;
      for (int e = 0; e < 60; e++) begin
         edge1();
         checks++;
         if ({note, gate, step, step_strobe} !== {m_note, m_gate, m_step, m_strobe}) begin
            failures++;
            $display("FAIL period0 e=%0d got %h want %h", e, {note, gate, step, step_strobe}, {m_note, m_gate, m_step, m_strobe});
         end
         if (last_tk) ntk++;
         if (step_strobe) nstb++;
      end
      checks++;
      if (nstb != ntk || ntk == 0) begin
         failures++;
         $display("FAIL period0_rate got %0d strobes want %0d (one per tick)", nstb, ntk);
      end
      run = 1'b0;
      edge1();
      gate_length = 16'd0; step_period = 16'd2; run = 1'b1; nstb = 0;
      for (int e = 0; e < 60; e++) begin
         edge1();
         checks++;
         if ({note, gate, step, step_strobe} !== {m_note, m_gate, m_step, m_strobe}) begin
            failures++;
            $display("FAIL gatelen0 e=%0d got %h want %h", e, {note, gate, step, step_strobe}, {m_note, m_gate, m_step, m_strobe});
         end
         if (gate) ngate++;
         if (step_strobe) nstb++;
      end
      checks++;
      if (ngate != 0 || nstb == 0) begin
         failures++;
         $display("FAIL gatelen0 got gate_edges=%0d strobes=%0d want 0 and >0", ngate, nstb);
      end
   endtask

   task automatic test_mid_step();
      bit found, got;
      int ntk;
      found = 0;
      do_reset();
      load_pattern(4'hF);
      last_step = 4'd3; step_period = 16'd8; gate_length = 16'd3; sc_hi = 1; sc_lo = 1; run = 1'b1;
      for (int e = 0; e < 300 && !found; e++) begin
         edge1();
         checks++;
         if ({note, gate, step, step_strobe} !== {m_note, m_gate, m_step, m_strobe}) begin
            failures++;
            $display("FAIL midstep e=%0d got %h want %h", e, {note, gate, step, step_strobe}, {m_note, m_gate, m_step, m_strobe});
         end
         if (m_play && m_step == 4'd1 && m_pos == 5) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL midstep_reach got timeout want step 1 at tick 5");
      end
      step_period = 16'd3;
      got = 0; ntk = 0;
      for (int e = 0; e < 40 && !got; e++) begin
         edge1();
         if (last_tk) ntk++;
         if (step_strobe) got = 1;
      end
      checks++;
      if (!got || step !== 4'd2 || ntk != 1) begin
         failures++;
         $display("FAIL period_shrink got strobe=%0b step=%0d ticks=%0d want 1 2 1", got, step, ntk);
      end
      last_step = 4'd1;
      got = 0; ntk = 0;
      for (int e = 0; e < 40 && !got; e++) begin
         edge1();
         if (last_tk) ntk++;
         if (step_strobe) got = 1;
      end
      checks++;
      if (!got || step !== 4'd0 || ntk != 3) begin
         failures++;
         $display("FAIL last_shrink got strobe=%0b step=%0d ticks=%0d want 1 0 3", got, step, ntk);
      end
   endtask

   task automatic test_stop_restart();
      bit found, got;
      int ntk;
      found = 0;
      do_reset();
      load_pattern(4'hF);
      last_step = 4'd3; step_period = 16'd4; gate_length = 16'd3; run = 1'b1;
      for (int e = 0; e < 200 && !found; e++) begin
         edge1();
         if (m_play && m_step == 4'd2 && m_pos == 1 && gate) found = 1;
      end
      run = 1'b0;
      edge1();
      checks++;
      if (!found || gate !== 1'b0 || step !== 4'd0 || step_strobe !== 1'b0) begin
         failures++;
         $display("FAIL stop got reached=%0b gate=%0b step=%0d strobe=%0b want 1 0 0 0", found, gate, step, step_strobe);
      end
      for (int e = 0; e < 7; e++) edge1();
      run = 1'b1;
      got = 0; ntk = 0;
      for (int e = 0; e < 40 && !got; e++) begin
         edge1();
         if (last_tk) ntk++;
         if (step_strobe) got = 1;
      end
      checks++;
      if (!got || step !== 4'd0 || note !== 8'd60 || ntk != 1) begin
         failures++;
         $display("FAIL restart got strobe=%0b step=%0d note=%0d ticks=%0d want 1 0 60 1", got, step, note, ntk);
      end
   endtask

   task automatic test_collision();
      bit done, got;
      done = 0;
      do_reset();
      load_pattern(4'hF);
      last_step = 4'd3; step_period = 16'd2; gate_length = 16'd1; run = 1'b1;
      for (int e = 0; e < 200 && !done; e++) begin
         if (m_play && run && tick_pend && m_pos + 1 >= 2 && m_step == 4'd1) begin
            wr_en = 1'b1; wr_addr = 4'd2; wr_note = 8'd50; wr_active = 1'b1;
            edge1();
            wr_en = 1'b0;
            done = 1;
            checks++;
            if (step_strobe !== 1'b1 || step !== 4'd2 || note !== 8'd67) begin
               failures++;
               $display("FAIL collision_old got strobe=%0b step=%0d note=%0d want 1 2 67", step_strobe, step, note);
            end
         end else begin
            edge1();
         end
      end
      got = 0;
      for (int e = 0; e < 100 && !got; e++) begin
         edge1();
         if (step_strobe && step == 4'd2) got = 1;
      end
      checks++;
      if (!done || !got || note !== 8'd50) begin
         failures++;
         $display("FAIL collision_new got written=%0b reload=%0b note=%0d want 1 1 50", done, got, note);
      end
   endtask

   task automatic test_reset_mid_play();
      bit got;
      do_reset();
      load_pattern(4'hF);
      last_step = 4'd3; step_period = 16'd2; gate_length = 16'd2; run = 1'b1;
      for (int e = 0; e < 40; e++) edge1();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({note, gate, step, step_strobe} !== 14'd0) begin
         failures++;
         $display("FAIL reset_async got %h want 0", {note, gate, step, step_strobe});
      end
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      got = 0;
      for (int e = 0; e < 40 && !got; e++) begin
         edge1();
         if (step_strobe) got = 1;
      end
      checks++;
      if (!got || note !== 8'd0 || gate !== 1'b0 || step !== 4'd0) begin
         failures++;
         $display("FAIL reset_mem got strobe=%0b note=%0d gate=%0b step=%0d want 1 0 0 0", got, note, gate, step);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 16; i++) write_step(4'(i), 8'($urandom_range(127)), 1'($urandom_range(1)));
         last_step   = 4'($urandom_range(15));
         step_period = 16'($urandom_range(5));
         gate_length = 16'($urandom_range(6));
         sc_rand = 1; run = 1'b1;
         for (int e = 0; e < 300; e++) begin
            if ($urandom_range(59) == 0) run = ~run;
            if ($urandom_range(79) == 0) step_period = 16'($urandom_range(5));
            if ($urandom_range(79) == 0) last_step = 4'($urandom_range(15));
            if ($urandom_range(79) == 0) gate_length = 16'($urandom_range(6));
            wr_en     = ($urandom_range(19) == 0);
            wr_addr   = 4'($urandom_range(15));
            wr_note   = 8'($urandom_range(255));
            wr_active = 1'($urandom_range(1));
            edge1();
            checks++;
            if ({note, gate, step, step_strobe} !== {m_note, m_gate, m_step, m_strobe}) begin
               failures++;
               $display("FAIL random r=%0d e=%0d got %h want %h", r, e, {note, gate, step, step_strobe}, {m_note, m_gate, m_step, m_strobe});
            end
         end
         wr_en = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1; sample_clock = 1'b0; run = 1'b0;
      wr_en = 1'b0; wr_addr = 4'd0; wr_note = 8'd0; wr_active = 1'b0;
      step_period = 16'd4; gate_length = 16'd2; last_step = 4'd3;
      sc_hi = 2; sc_lo = 2; sc_ph = 0; sc_rand = 0; last_tk = 1'b0;
      test_reset();
      test_basic_run();
      test_legato();
      test_degenerate();
      test_mid_step();
      test_stop_restart();
      test_collision();
      test_reset_mid_play();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
